// File: rtl/serial_det_arbiter_if.sv
// serial_det_arbiter_if: request/grant, result and counter readout signals of the lane arbiter
interface serial_det_arbiter_if #(
  parameter int N = 4,
  parameter int LW = 2,
  parameter int CNT_W = 8
);
  logic [N-1:0] req;
  logic [N-1:0] bit_in;
  logic [N-1:0] en;
  logic [N-1:0] gnt;
  logic [N-1:0] ctx_clr;
  logic det_valid;
  logic [LW-1:0] det_lane;
  logic det_y;
  logic cnt_clr;
  logic [LW-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_rd;
  modport master(
    output req, bit_in, en, ctx_clr, cnt_clr, cnt_sel,
    input gnt, det_valid, det_lane, det_y, cnt_rd
  );
  modport slave(
    input req, bit_in, en, ctx_clr, cnt_clr, cnt_sel,
    output gnt, det_valid, det_lane, det_y, cnt_rd
  );
endinterface

// File: rtl/serial_det_arbiter.sv
// serial_det_arbiter: round-robin sharing of one "11" Mealy detector across N serial lanes
module serial_det_arbiter #(
  parameter int N = 4,
  parameter int LW = 2,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  serial_det_arbiter_if.slave bus
);
  logic [LW-1:0] ptr, win, dl;
  logic [LW:0] s;
  logic hit, y, dv, dy;
  logic [N-1:0] elig, ctx;
  logic [CNT_W-1:0] cnt [N];
  // first eligible lane at or after ptr, wrapping from N-1 back to 0
  always_comb begin
    elig = bus.req & bus.en;
    win = '0;
    hit = 1'b0;
    s = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (LW+1)'(k);
      s = s >= (LW+1)'(N) ? s - (LW+1)'(N) : s;
      if (!hit && elig[s[LW-1:0]]) begin
        hit = 1'b1;
        win = s[LW-1:0];
      end
    end
  end
  assign y = ctx[win] & bus.bit_in[win];
  assign bus.gnt = (rst && hit) ? {{(N-1){1'b0}}, 1'b1} << win : '0;
  assign bus.det_valid = dv;
  assign bus.det_lane = dl;
  assign bus.det_y = dy;
  assign bus.cnt_rd = int'(bus.cnt_sel) < N ? cnt[bus.cnt_sel] : '0;
  // result register, rotating pointer and per-lane context; a context clear beats the update
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= '0;
      ctx <= '0;
      dv <= 1'b0;
      dl <= '0;
      dy <= 1'b0;
    end else begin
      dv <= hit;
      if (hit) begin
        dl <= win;
        dy <= y;
        ptr <= win == LW'(N-1) ? '0 : win + 1'b1;
      end
      ctx <= ((ctx & ~bus.gnt) | (bus.bit_in & bus.gnt)) & ~bus.ctx_clr;
    end
  // saturating per-lane match counters; a global clear beats an increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (bus.cnt_clr) cnt[i] <= '0;
        else if (bus.gnt[i] && y && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
endmodule

// File: tb/tb_serial_det_arbiter.sv
// tb_serial_det_arbiter: scoreboard bench for the round-robin shared "11" detector
module tb_serial_det_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [3:0] mctx;
  logic [1:0] mcnt [4];
  int mptr;
  logic [1:0] last_lane;
  logic last_y;
  logic [2:0] q [$];
  logic [5:0] l0_bits = 6'b101110;
  logic [5:0] l0_y = 6'b001100;

  serial_det_arbiter_if #(.N(4), .LW(2), .CNT_W(2)) bus();
  serial_det_arbiter #(.N(4), .LW(2), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mctx = '0;
    for (int i = 0; i < 4; i++) mcnt[i] = '0;
    mptr = 0;
    q.delete();
    last_lane = '0;
    last_y = 1'b0;
  endtask

  task automatic check_counts();
    bus.req = '0;
    bus.ctx_clr = '0;
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cnt_sel = 2'(i);
      #1;
      check("cnt_rd", 32'(bus.cnt_rd), 32'(mcnt[i]));
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] b, input logic [3:0] e,
                     input logic [3:0] cc, input logic cl);
    int w;
    logic [3:0] el;
    logic yy;
    logic [2:0] ex;
    bus.req = r;
    bus.bit_in = b;
    bus.en = e;
    bus.ctx_clr = cc;
    bus.cnt_clr = cl;
    #1;
    el = r & e;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && el[2'((mptr + k) % 4)]) w = (mptr + k) % 4;
    check("gnt", 32'(bus.gnt), w < 0 ? 32'd0 : 32'd1 << w);
    if (w >= 0) begin
      yy = mctx[2'(w)] & b[2'(w)];
      q.push_back({2'(w), yy});
      mctx[2'(w)] = b[2'(w)];
      mptr = (w + 1) % 4;
      if (yy && mcnt[2'(w)] != 2'd3) mcnt[2'(w)] = mcnt[2'(w)] + 2'd1;
    end
    mctx = mctx & ~cc;
    if (cl) for (int i = 0; i < 4; i++) mcnt[i] = '0;
    @(posedge clk);
    @(negedge clk);
    check("det_valid", 32'(bus.det_valid), 32'(w >= 0));
    if (w >= 0) begin
      if (q.size() > 0) begin
        ex = q.pop_front();
        check("det_lane", 32'(bus.det_lane), 32'(ex[2:1]));
        check("det_y", 32'(bus.det_y), 32'(ex[0]));
        last_lane = ex[2:1];
        last_y = ex[0];
      end
    end else
      check("det_hold", 32'({bus.det_lane, bus.det_y}), 32'({last_lane, last_y}));
  endtask

  task automatic do_reset();
    bus.req = 4'hF;
    bus.en = 4'hF;
    #2 rst = 1'b0;
    #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_valid", 32'(bus.det_valid), 0);
    check("rst_lane", 32'(bus.det_lane), 0);
    check("rst_y", 32'(bus.det_y), 0);
    model_reset();
    check_counts();
    rst = 1'b1;
  endtask

  initial begin
    bus.req = 4'hF;
    bus.en = 4'hF;
    bus.bit_in = '0;
    bus.ctx_clr = '0;
    bus.cnt_clr = 1'b0;
    bus.cnt_sel = '0;
    model_reset();
    #1;
    check("init_gnt", 32'(bus.gnt), 0);
    check("init_valid", 32'(bus.det_valid), 0);
    repeat (2) @(posedge clk);
    check("init_gnt_held", 32'(bus.gnt), 0);
    @(negedge clk);
    check_counts();
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(4'b0001, {3'b000, l0_bits[i]}, 4'hF, '0, 1'b0);
      check("l0_seq_y", 32'(bus.det_y), 32'(l0_y[i]));
    end
    check_counts();
    bus.cnt_sel = 2'd0;
    #1;
    check("l0_cnt", 32'(bus.cnt_rd), 2);
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(4'hF, 4'b0100, 4'hF, '0, 1'b0);
      check("rr_lane", 32'(bus.det_lane), i % 4);
    end
    check_counts();

    do_reset();
    for (int i = 0; i < 6; i++) cyc(4'b0010, 4'b0010, 4'hF, '0, 1'b0);
    bus.cnt_sel = 2'd1;
    #1;
    check("sat_cnt", 32'(bus.cnt_rd), 3);
    @(negedge clk);
    cyc('0, '0, 4'hF, '0, 1'b1);
    check_counts();

    cyc(4'b0010, 4'b0010, 4'hF, 4'b0010, 1'b0);
    check("ctxclr_y_old", 32'(bus.det_y), 1);
    cyc(4'b0010, 4'b0010, 4'hF, '0, 1'b0);
    check("ctxclr_y_new", 32'(bus.det_y), 0);

    for (int i = 0; i < 6; i++) begin
      cyc(4'hF, 4'hF, 4'b1011, '0, 1'b0);
      check("masked_lane2", 32'(bus.gnt[2]), 0);
    end
    do_reset();
    cyc(4'hF, 4'hF, 4'hF, '0, 1'b0);
    check("post_rst_lane", 32'(bus.det_lane), 0);
    check("post_rst_y", 32'(bus.det_y), 0);

    for (int i = 0; i < 60; i++)
      cyc(4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF,
          $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'h0, $urandom_range(0, 15) == 0);
    check_counts();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
